rr_arbiter_4: RTL and testbench

//  Round-robin arbiter for four requesters sharing one resource slot. Selects
//  an owner index (2 bits) and drives the matching one-hot grant through a
//  2-to-4 decode. Holds each grant until the owner releases it or the hold

---
 rtl/rr_arbiter_4.sv | 113 +++++++++++
 tb/tb_rr_arbiter_4.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter for a single shared resource slot.
// The owner keeps its grant until it releases it or the MAX_HOLD limit forces a handoff.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q;
  logic [1:0]    owner_q, last_q;
  logic [3:0]    gnt_q;
  logic [CW-1:0] cnt_q;
  logic          to_q, busy_q;

  logic [3:0]    cand_req;
  logic [1:0]    base, probe, win;
  logic          found, expire;

  function automatic logic [3:0] dec2(input logic [1:0] i);
    dec2 = 4'b0001 << i;
  endfunction

  // While busy the owner is masked and the scan starts just past it, so a
  // handoff is the same round-robin walk as an idle grant from last_q.
  always_comb begin
    base     = (state_q == BUSY) ? owner_q : last_q;
    cand_req = req;
    if (state_q == BUSY) cand_req[owner_q] = 1'b0;
    found = 1'b0;
    win   = base;
    probe = base;
    for (int k = 4; k >= 1; k--) begin
      probe = base + k[1:0];
      if (cand_req[probe]) begin
        found = 1'b1;
        win   = probe;
      end
    end
    expire = (MAX_HOLD != 0) && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= BUSY;
            owner_q <= win;
            gnt_q   <= dec2(win);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (!req[owner_q]) begin
            // Release outranks expiry, so no timeout pulse on this path.
            last_q <= owner_q;
            cnt_q  <= '0;
            if (found) begin
              owner_q <= win;
              gnt_q   <= dec2(win);
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if (expire) begin
            cnt_q <= '0;
            if (found) begin
              last_q  <= owner_q;
              owner_q <= win;
              gnt_q   <= dec2(win);
              to_q    <= 1'b1;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = owner_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4 (MAX_HOLD=4): directed vector table, hand-written
// corner sequences, then random requests against a cycle-level ownership model.
module tb_rr_arbiter_4;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy, timeout;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] eg;
    logic [1:0] ei;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                         input logic et);
    chk({tag, ".gnt"},     gnt, eg);
    chk({tag, ".busy"},    {3'b0, busy}, {3'b0, (eg != 4'b0)});
    chk({tag, ".idx"},     {2'b0, gnt_idx}, {2'b0, ei});
    chk({tag, ".timeout"}, {3'b0, timeout}, {3'b0, et});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                     input logic [1:0] ei, input logic et);
    vec_t v;
    v.r = r; v.rq = rq; v.eg = eg; v.ei = ei; v.et = et;
    tbl.push_back(v);
  endtask

  // Reference: owner as an integer (-1 = nobody), cycles-held count from 1.
  int         m_own, m_last, m_held;
  logic [1:0] m_idx;
  logic       m_to;

  function automatic int rr_find(input logic [3:0] r, input int from, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq);
    int c;
    m_to = 1'b0;
    if (r) begin
      m_own = -1; m_last = 3; m_held = 0; m_idx = 2'd0;
    end else if (m_own < 0) begin
      c = rr_find(rq, m_last, -1);
      if (c >= 0) begin m_own = c; m_held = 1; end
    end else if (!rq[m_own]) begin
      m_last = m_own;
      m_own  = rr_find(rq, m_own, m_own);
      m_held = 1;
    end else if (m_held == MH) begin
      c = rr_find(rq, m_own, m_own);
      if (c >= 0) begin m_last = m_own; m_own = c; m_to = 1'b1; end
      m_held = 1;
    end else begin
      m_held++;
    end
    if (m_own >= 0) m_idx = 2'(m_own);
  endtask

  function automatic logic [3:0] m_gnt();
    logic [3:0] e;
    e = 4'b0001;
    if (m_own < 0) return 4'b0000;
    return e << m_own;
  endfunction

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset, request 1111 -> 0001 then owners rotate 0,1,2,3,0 on single-cycle drops.
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 0);
    add(0, 4'b1110, 4'b0010, 2'd1, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 0);
    add(0, 4'b1111, 4'b0010, 2'd1, 0);
    add(0, 4'b1101, 4'b0100, 2'd2, 0);
    add(0, 4'b1111, 4'b0100, 2'd2, 0);
    add(0, 4'b1111, 4'b0100, 2'd2, 0);
    add(0, 4'b1011, 4'b1000, 2'd3, 0);
    add(0, 4'b1111, 4'b1000, 2'd3, 0);
    add(0, 4'b1111, 4'b1000, 2'd3, 0);
    add(0, 4'b0111, 4'b0001, 2'd0, 0);
    // Two contenders held: four cycles each, timeout on every switch.
    add(1, 4'b0011, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0011, 4'b0001, 2'd0, 0);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0010, 2'd1, 0);
    add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0001, 2'd0, 0);
    // Lone requester past the hold limit keeps the grant, no timeout.
    add(1, 4'b0000, 4'b0000, 2'd0, 0);
    for (int i = 0; i < 10; i++) add(0, 4'b0100, 4'b0100, 2'd2, 0);
    // Going idle keeps the last owner index.
    add(0, 4'b0000, 4'b0000, 2'd2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      req = tbl[i].rq;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ei, tbl[i].et);
    end

    // Owner 1 releases on its expiry edge with req[3] waiting.
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b0010; tick();
    chk_out("rel_exp.grant1", 4'b0010, 2'd1, 1'b0);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) tick();
    chk_out("rel_exp.held", 4'b0010, 2'd1, 1'b0);
    req = 4'b1000; tick();
    chk_out("rel_exp.hand", 4'b1000, 2'd3, 1'b0);
    tick();
    chk_out("rel_exp.after", 4'b1000, 2'd3, 1'b0);

    // Reset mid-grant on 2: pointer returns to 3 so requester 0 wins next.
    rst = 1'b1; req = 4'b0000; tick();
    rst = 1'b0; req = 4'b0100; tick();
    chk_out("rst_mid.own2", 4'b0100, 2'd2, 1'b0);
    rst = 1'b1; req = 4'b0101; tick();
    chk_out("rst_mid.clr", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; tick();
    chk_out("rst_mid.regrant", 4'b0001, 2'd0, 1'b0);

    // Random phase against the model; requests are sticky so holds can expire.
    rst = 1'b1; req = 4'b0000;
    model_step(rst, req);
    tick();
    chk_out("rnd.rst", m_gnt(), m_idx, m_to);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      model_step(rst, req);
      tick();
      chk_out($sformatf("rnd%0d", i), m_gnt(), m_idx, m_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
